// File: rtl/watch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : watch_pkg
// Description : Shared types and constants for the watch time-setting
//               controller: set-mode state encoding, field-select codes and
//               default timing values.
// Revision    : 1.0 - initial release
// ============================================================================
package watch_pkg;

  // Set-mode states; the encoding doubles as the field_sel display code.
  typedef enum logic [1:0] {
    RUN      = 2'd0,
    SET_HOUR = 2'd1,
    SET_MIN  = 2'd2,
    SET_SEC  = 2'd3
  } set_state_t;

  localparam logic [1:0] FIELD_NONE   = 2'd0;
  localparam logic [1:0] FIELD_HOUR   = 2'd1;
  localparam logic [1:0] FIELD_MINUTE = 2'd2;
  localparam logic [1:0] FIELD_SECOND = 2'd3;

  // Defaults assume a 100 MHz system clock.
  localparam int DEF_DEBOUNCE_CYCLES = 1_000_000;
  localparam int DEF_REPEAT_DELAY    = 50_000_000;
  localparam int DEF_REPEAT_PERIOD   = 20_000_000;

  // Field rotation used by the select button: hour -> minute -> second -> hour.
  function automatic logic [1:0] next_field(input logic [1:0] cur);
    return (cur == FIELD_SECOND) ? FIELD_HOUR : (cur + 2'd1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/btn_debounce.sv
`default_nettype none
// ============================================================================
// Module      : btn_debounce
// Description : One push-button path: 2-FF synchronizer, stable-sample
//               debounce counter, debounced level and one-cycle press pulse
//               on a debounced 0->1 transition. A button held through reset
//               is not reported until it has been released and pressed again.
// Revision    : 1.0 - initial release
// ============================================================================
module btn_debounce
  import watch_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic i_btn,
  output logic o_level,
  output logic o_press
);

  localparam int c_CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DEBOUNCE_CYCLES - 1);

  logic               r_sync1;
  logic               r_sync2;
  logic               r_level;
  logic               r_press;
  logic [c_CNT_W-1:0] r_cnt;
  logic [1:0]         r_fill;   // synchronizer fill after reset
  logic               r_armed;  // a released level has been observed

  // Synchronize, debounce and detect presses; press is only reported once armed.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_level <= 1'b0;
      r_press <= 1'b0;
      r_cnt   <= '0;
      r_fill  <= 2'd0;
      r_armed <= 1'b0;
    end else begin
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;
      r_press <= 1'b0;
      if (r_fill != 2'd2) begin
        r_fill <= r_fill + 2'd1;
      end
      // Arm only after a genuine post-reset sample shows the button released.
      if ((r_fill == 2'd2) && !r_sync2) begin
        r_armed <= 1'b1;
      end
      if (r_sync2 == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == c_CNT_LAST) begin
        r_cnt   <= '0;
        r_level <= r_sync2;
        r_press <= r_sync2 & r_armed;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_level = r_level;
  assign o_press = r_press;

endmodule
`default_nettype wire

// File: rtl/watch_set_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : watch_set_ctrl
// Description : Time-setting controller. Debounces mode/select/inc buttons,
//               runs the RUN/SET_HOUR/SET_MIN/SET_SEC state machine and
//               drives the mode / change_* / valid_response handshake to the
//               time counters. Same-cycle events: mode > select > inc, the
//               losers are dropped.
//               Optional macro WATCH_AUTO_REPEAT_EN adds inc auto-repeat.
// Revision    : 1.0 - initial release
// ============================================================================
module watch_set_ctrl
  import watch_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_mode,
  input  logic       btn_select,
  input  logic       btn_inc,
  output logic       mode,
  output logic       change_hour,
  output logic       change_minute,
  output logic       change_second,
  output logic       valid_response,
  output logic [1:0] field_sel
);

  localparam logic [1:0] c_ST_RUN      = RUN;
  localparam logic [1:0] c_ST_SET_HOUR = SET_HOUR;
  localparam logic [1:0] c_ST_SET_MIN  = SET_MIN;
  localparam logic [1:0] c_ST_SET_SEC  = SET_SEC;

  logic w_mode_level, w_mode_press;
  logic w_sel_level,  w_sel_press;
  logic w_inc_level,  w_inc_press;
  logic w_rep_fire;
  logic w_inc_ev;
  logic w_state_chg;
  logic [1:0] w_next;

  logic [1:0] r_state;
  logic       r_mode;
  logic       r_change_hour;
  logic       r_change_minute;
  logic       r_change_second;
  logic       r_valid;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_mode (
    .clk(clk), .rst(rst), .i_btn(btn_mode), .o_level(w_mode_level), .o_press(w_mode_press)
  );
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_select (
    .clk(clk), .rst(rst), .i_btn(btn_select), .o_level(w_sel_level), .o_press(w_sel_press)
  );
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_inc (
    .clk(clk), .rst(rst), .i_btn(btn_inc), .o_level(w_inc_level), .o_press(w_inc_press)
  );

  // Only press events drive the FSM; mode/select levels are informational.
  logic w_unused_lvl;
  assign w_unused_lvl = ^{w_mode_level, w_sel_level};

  // An inc (real or repeated) survives only if no higher-priority event coincides.
  assign w_inc_ev    = (w_inc_press | w_rep_fire) & ~w_mode_press & ~w_sel_press;
  assign w_state_chg = w_mode_press | (w_sel_press & (r_state != c_ST_RUN));

  // Next-state selection with mode taking priority over select.
  always_comb begin
    w_next = r_state;
    if (w_mode_press) begin
      w_next = (r_state == c_ST_RUN) ? c_ST_SET_HOUR : c_ST_RUN;
    end else if (w_sel_press && (r_state != c_ST_RUN)) begin
      w_next = next_field(r_state);
    end
  end

  // State register and registered handshake outputs; change pulses last one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state         <= c_ST_RUN;
      r_mode          <= 1'b0;
      r_change_hour   <= 1'b0;
      r_change_minute <= 1'b0;
      r_change_second <= 1'b0;
      r_valid         <= 1'b0;
    end else begin
      r_state         <= w_next;
      r_mode          <= (w_next != c_ST_RUN);
      r_change_hour   <= w_inc_ev && (r_state == c_ST_SET_HOUR);
      r_change_minute <= w_inc_ev && (r_state == c_ST_SET_MIN);
      r_change_second <= w_inc_ev && (r_state == c_ST_SET_SEC);
      r_valid         <= w_inc_ev && (r_state != c_ST_RUN);
    end
  end

`ifdef WATCH_AUTO_REPEAT_EN
  localparam int c_REP_W = $clog2(REPEAT_DELAY + 1);
  localparam logic [c_REP_W-1:0] c_REP_FIRE   = c_REP_W'(REPEAT_DELAY);
  localparam logic [c_REP_W-1:0] c_REP_RELOAD = c_REP_W'(REPEAT_DELAY - REPEAT_PERIOD + 1);

  // Cycles since the inc press (1 on the cycle after it); 0 means idle.
  logic [c_REP_W-1:0] r_rep_cnt;

  assign w_rep_fire = (r_rep_cnt == c_REP_FIRE) && w_inc_level;

  // Repeat timer: starts on an inc press in a set state, reloads after each repeat.
  always_ff @(posedge clk) begin
    if (rst || w_state_chg || !w_inc_level || (r_state == c_ST_RUN)) begin
      r_rep_cnt <= '0;
    end else if (w_inc_press) begin
      r_rep_cnt <= c_REP_W'(1);
    end else if (w_rep_fire) begin
      r_rep_cnt <= c_REP_RELOAD;
    end else if (r_rep_cnt != '0) begin
      r_rep_cnt <= r_rep_cnt + 1'b1;
    end
  end
`else
  localparam logic c_REP_CFG = (REPEAT_DELAY >= REPEAT_PERIOD);

  assign w_rep_fire = 1'b0;

  // Without auto-repeat the held inc level and repeat timing are not needed.
  logic w_unused_rep;
  assign w_unused_rep = ^{w_inc_level, w_state_chg, c_REP_CFG};
`endif

  assign mode           = r_mode;
  assign change_hour    = r_change_hour;
  assign change_minute  = r_change_minute;
  assign change_second  = r_change_second;
  assign valid_response = r_valid;
  assign field_sel      = r_state;

endmodule
`default_nettype wire
